// File: rtl/flag_unit_pkg.sv
// Shared encodings for the {N,Z,V} condition-flag path: ALU op codes and flag bit positions.
package flag_unit_pkg;

    typedef enum logic [1:0] {
        AluAdd   = 2'd0,
        AluSub   = 2'd1,
        AluLogic = 2'd2,
        AluShift = 2'd3
    } alu_op_e;

    localparam int unsigned FlagN = 2;
    localparam int unsigned FlagZ = 1;
    localparam int unsigned FlagV = 0;

endpackage

// File: rtl/flag_unit_flag_calc.sv
// Combinational {N,Z,V} computation from an EX-stage ALU result and its operands.
module flag_calc
    import flag_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] r,
    input  logic             prev_v,
    output logic [2:0]       nzv
);

    logic a_msb, b_msb, r_msb;
    logic overflow_unused;

    assign a_msb = a[WIDTH-1];
    assign b_msb = b[WIDTH-1];
    assign r_msb = r[WIDTH-1];
    // Only operand sign bits matter for overflow.
    assign overflow_unused = ^{a[WIDTH-2:0], b[WIDTH-2:0]};

    always_comb begin
        nzv        = '0;
        nzv[FlagN] = r_msb;
        nzv[FlagZ] = (r == '0);
        unique case (alu_op_e'(op))
            AluAdd:   nzv[FlagV] = (a_msb == b_msb) & (r_msb != a_msb);
            AluSub:   nzv[FlagV] = (a_msb != b_msb) & (r_msb != a_msb);
            AluLogic,
            AluShift: nzv[FlagV] = prev_v;
            default:  nzv[FlagV] = prev_v;
        endcase
    end

endmodule

// File: rtl/flag_unit.sv
// Flag producer: computes EX flags, holds one pending update, commits it, forwards youngest flags.
module flag_unit
    import flag_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic             ex_setFlags,
    input  logic [1:0]       ex_aluOp,
    input  logic [WIDTH-1:0] ex_a,
    input  logic [WIDTH-1:0] ex_b,
    input  logic [WIDTH-1:0] ex_result,
    input  logic             stall,
    input  logic             flush,
    output logic [2:0]       flags,
    output logic [2:0]       archFlags,
    output logic             flagsPending,
    output logic             flagHazard
);

    logic [2:0] arch_q;
    logic [2:0] pend_q;
    logic       pend_valid_q;
    logic [2:0] calc_nzv;
    logic       capture;

    assign flags        = pend_valid_q ? pend_q : arch_q;
    assign archFlags    = arch_q;
    assign flagsPending = pend_valid_q;
    assign flagHazard   = ex_valid & ex_setFlags;
    assign capture      = ex_valid & ex_setFlags & ~stall & ~flush;

    // V retain source is the forwarded view so a pending ADD/SUB overflow survives.
    flag_calc #(
        .WIDTH (WIDTH)
    ) u_flag_calc (
        .op     (ex_aluOp),
        .a      (ex_a),
        .b      (ex_b),
        .r      (ex_result),
        .prev_v (flags[FlagV]),
        .nzv    (calc_nzv)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arch_q       <= 3'b000;
            pend_q       <= 3'b000;
            pend_valid_q <= 1'b0;
        end else if (flush) begin
            // Squash the pending entry without committing it.
            pend_valid_q <= 1'b0;
        end else if (!stall) begin
            if (pend_valid_q) begin
                arch_q <= pend_q;
            end
            pend_valid_q <= capture;
            if (capture) begin
                pend_q <= calc_nzv;
            end
        end
    end

endmodule

// File: tb/tb_flag_unit.sv
// Directed self-checking bench for flag_unit (WIDTH=16).
module tb_flag_unit;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_setFlags;
    logic [1:0]  ex_aluOp;
    logic [15:0] ex_a;
    logic [15:0] ex_b;
    logic [15:0] ex_result;
    logic        stall;
    logic        flush;
    logic [2:0]  flags;
    logic [2:0]  archFlags;
    logic        flagsPending;
    logic        flagHazard;

    int errors = 0;
    int checks = 0;

    localparam logic [1:0] OpAdd   = 2'd0;
    localparam logic [1:0] OpSub   = 2'd1;
    localparam logic [1:0] OpLogic = 2'd2;

    flag_unit #(
        .WIDTH (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_valid     (ex_valid),
        .ex_setFlags  (ex_setFlags),
        .ex_aluOp     (ex_aluOp),
        .ex_a         (ex_a),
        .ex_b         (ex_b),
        .ex_result    (ex_result),
        .stall        (stall),
        .flush        (flush),
        .flags        (flags),
        .archFlags    (archFlags),
        .flagsPending (flagsPending),
        .flagHazard   (flagHazard)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic [1:0] op,
                         input logic [15:0] a, input logic [15:0] b, input logic [15:0] r);
        ex_valid    = v;
        ex_setFlags = s;
        ex_aluOp    = op;
        ex_a        = a;
        ex_b        = b;
        ex_result   = r;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, OpAdd, 16'h0, 16'h0, 16'h0);
        stall = 1'b0;
        flush = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    // {flags, archFlags, flagsPending} packed for compact comparison.
    task automatic test_reset();
        do_reset();
        checks++;
        if ({flags, archFlags, flagsPending} !== 7'b000_000_0) begin
            errors++;
            $display("FAIL reset_idle: got %b required %b", {flags, archFlags, flagsPending},
                     7'b000_000_0);
        end
        drive(1'b1, 1'b1, OpAdd, 16'h7FFF, 16'h0001, 16'h8000);
        step();
        drive(1'b0, 1'b0, OpAdd, 16'h0, 16'h0, 16'h0);
        checks++;
        if ({flags, flagsPending} !== 4'b101_1) begin
            errors++;
            $display("FAIL reset_pre_pending: got %b required %b", {flags, flagsPending}, 4'b101_1);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({flags, archFlags, flagsPending} !== 7'b000_000_0) begin
            errors++;
            $display("FAIL reset_async: got %b required %b", {flags, archFlags, flagsPending},
                     7'b000_000_0);
        end
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if ({flags, archFlags, flagsPending} !== 7'b000_000_0) begin
            errors++;
            $display("FAIL reset_no_commit: got %b required %b", {flags, archFlags, flagsPending},
                     7'b000_000_0);
        end
    endtask

    task automatic test_add();
        do_reset();
        drive(1'b1, 1'b1, OpAdd, 16'h7FFF, 16'h0001, 16'h8000);
        step();
        drive(1'b0, 1'b0, OpAdd, 16'h0, 16'h0, 16'h0);
        checks++;
        if ({flags, archFlags, flagsPending} !== 7'b101_000_1) begin
            errors++;
            $display("FAIL add_pending: got %b required %b", {flags, archFlags, flagsPending},
                     7'b101_000_1);
        end
        step();
        checks++;
        if ({flags, archFlags, flagsPending} !== 7'b101_101_0) begin
            errors++;
            $display("FAIL add_commit: got %b required %b", {flags, archFlags, flagsPending},
                     7'b101_101_0);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(1'b1, 1'b1, OpSub, 16'h0005, 16'h0005, 16'h0000);
        step();
        checks++;
        if ({flags, flagsPending} !== 4'b010_1) begin
            errors++;
            $display("FAIL b2b_sub: got %b required %b", {flags, flagsPending}, 4'b010_1);
        end
        drive(1'b1, 1'b1, OpLogic, 16'h00F0, 16'hFF0F, 16'hFFFF);
        step();
        checks++;
        if ({flags, archFlags, flagsPending} !== 7'b100_010_1) begin
            errors++;
            $display("FAIL b2b_logic: got %b required %b", {flags, archFlags, flagsPending},
                     7'b100_010_1);
        end
        // ADD overflow pending, then LOGIC must keep V=1 from the forwarded view.
        drive(1'b1, 1'b1, OpAdd, 16'h7FFF, 16'h0001, 16'h8000);
        step();
        checks++;
        if ({flags, archFlags, flagsPending} !== 7'b101_100_1) begin
            errors++;
            $display("FAIL b2b_add: got %b required %b", {flags, archFlags, flagsPending},
                     7'b101_100_1);
        end
        drive(1'b1, 1'b1, OpLogic, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        step();
        drive(1'b0, 1'b0, OpAdd, 16'h0, 16'h0, 16'h0);
        checks++;
        if ({flags, archFlags, flagsPending} !== 7'b101_101_1) begin
            errors++;
            $display("FAIL b2b_v_retain: got %b required %b", {flags, archFlags, flagsPending},
                     7'b101_101_1);
        end
    endtask

    task automatic test_stall();
        do_reset();
        drive(1'b1, 1'b1, OpAdd, 16'h7FFF, 16'h0001, 16'h8000);
        step();
        // A setter sits in EX during the stall and must not be captured.
        drive(1'b1, 1'b1, OpSub, 16'h0003, 16'h0003, 16'h0000);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({flags, archFlags, flagsPending} !== 7'b101_000_1) begin
                errors++;
                $display("FAIL stall_hold_%0d: got %b required %b", i,
                         {flags, archFlags, flagsPending}, 7'b101_000_1);
            end
        end
        stall = 1'b0;
        drive(1'b0, 1'b0, OpAdd, 16'h0, 16'h0, 16'h0);
        step();
        checks++;
        if ({flags, archFlags, flagsPending} !== 7'b101_101_0) begin
            errors++;
            $display("FAIL stall_release: got %b required %b", {flags, archFlags, flagsPending},
                     7'b101_101_0);
        end
    endtask

    task automatic test_flush();
        do_reset();
        drive(1'b1, 1'b1, OpAdd, 16'h7FFF, 16'h0001, 16'h8000);
        step();
        drive(1'b1, 1'b1, OpSub, 16'h0005, 16'h0003, 16'h0002);
        step();
        checks++;
        if ({flags, archFlags, flagsPending} !== 7'b000_101_1) begin
            errors++;
            $display("FAIL flush_pre: got %b required %b", {flags, archFlags, flagsPending},
                     7'b000_101_1);
        end
        drive(1'b1, 1'b1, OpLogic, 16'h0000, 16'h0000, 16'h0000);
        flush = 1'b1;
        stall = 1'b1;
        step();
        flush = 1'b0;
        stall = 1'b0;
        drive(1'b0, 1'b0, OpAdd, 16'h0, 16'h0, 16'h0);
        checks++;
        if ({flags, archFlags, flagsPending} !== 7'b101_101_0) begin
            errors++;
            $display("FAIL flush_squash: got %b required %b", {flags, archFlags, flagsPending},
                     7'b101_101_0);
        end
        step();
        checks++;
        if ({flags, archFlags, flagsPending} !== 7'b101_101_0) begin
            errors++;
            $display("FAIL flush_after: got %b required %b", {flags, archFlags, flagsPending},
                     7'b101_101_0);
        end
    endtask

    task automatic test_hazard();
        do_reset();
        drive(1'b1, 1'b1, OpSub, 16'h0001, 16'h0001, 16'h0000);
        #1;
        checks++;
        if (flagHazard !== 1'b1) begin
            errors++;
            $display("FAIL hazard_set: got %b required %b", flagHazard, 1'b1);
        end
        drive(1'b0, 1'b1, OpSub, 16'h0001, 16'h0001, 16'h0000);
        #1;
        checks++;
        if (flagHazard !== 1'b0) begin
            errors++;
            $display("FAIL hazard_invalid: got %b required %b", flagHazard, 1'b0);
        end
        step();
        checks++;
        if ({flags, flagsPending} !== 4'b000_0) begin
            errors++;
            $display("FAIL hazard_no_capture: got %b required %b", {flags, flagsPending}, 4'b000_0);
        end
        drive(1'b1, 1'b0, OpSub, 16'h0001, 16'h0001, 16'h0000);
        #1;
        checks++;
        if (flagHazard !== 1'b0) begin
            errors++;
            $display("FAIL hazard_nosetter: got %b required %b", flagHazard, 1'b0);
        end
        step();
        checks++;
        if ({flags, flagsPending} !== 4'b000_0) begin
            errors++;
            $display("FAIL hazard_nosetter_cap: got %b required %b", {flags, flagsPending},
                     4'b000_0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        drive(1'b0, 1'b0, OpAdd, 16'h0, 16'h0, 16'h0);
        test_reset();
        test_add();
        test_back_to_back();
        test_stall();
        test_flush();
        test_hazard();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
